// File: rtl/arb_merge_pkg.sv
// arb_merge_pkg: shared helpers, channel index type and pointer reset value for arb_merge_rr_sync
package arb_merge_pkg;
  localparam int MAX_CH = 16;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  typedef logic [clog2(MAX_CH)-1:0] ch_idx_t;
  function automatic int ptr_rst(input int n_ch);
    return n_ch - 1;
  endfunction
endpackage

// File: rtl/arb_in_fifo.sv
// arb_in_fifo: per-channel synchronous FIFO; an extra wrap bit on each pointer separates full from empty
module arb_in_fifo
  import arb_merge_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] rdata_o
);
  localparam int AW = clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic do_push, do_pop;
  assign empty_o = wr_q == rd_q;
  assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i & ~full_o;
  assign do_pop = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_q[AW-1:0]];
  always_comb begin
    wr_d = do_push ? wr_q + (AW+1)'(1) : wr_q;
    rd_d = do_pop ? rd_q + (AW+1)'(1) : rd_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/arb_merge_rr_sync.sv
// arb_merge_rr_sync: N-to-1 round-robin merge of per-channel FIFOs into a registered valid/ready output.
// Define ARB_LOCK_EN to add i_last/o_last and keep the grant on one channel until its last beat.
module arb_merge_rr_sync
  import arb_merge_pkg::*;
#(
  parameter int N_CH       = 8,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH-1:0]            i_valid,
  input  logic [N_CH*DATA_WIDTH-1:0] i_data,
  output logic [N_CH-1:0]            o_ready,
  output logic                       o_valid,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic [clog2(N_CH)-1:0]     o_src,
  input  logic                       i_ready
`ifdef ARB_LOCK_EN
  ,
  input  logic [N_CH-1:0]            i_last,
  output logic                       o_last
`endif
);
  localparam int SW = clog2(N_CH);
`ifdef ARB_LOCK_EN
  localparam int FW = DATA_WIDTH + 1;
`else
  localparam int FW = DATA_WIDTH;
`endif
  logic [N_CH-1:0] full, empty, req, elig, pop;
  logic [FW-1:0] head [N_CH];
  logic [FW-1:0] head_g;
  logic load, take, last_g;
  int gnt;
  logic o_valid_q, o_valid_d;
  logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
  logic [SW-1:0] o_src_q, o_src_d;
  ch_idx_t ptr_q, ptr_d;
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [FW-1:0] wd;
`ifdef ARB_LOCK_EN
    assign wd = {i_last[k], i_data[k*DATA_WIDTH +: DATA_WIDTH]};
`else
    assign wd = i_data[k*DATA_WIDTH +: DATA_WIDTH];
`endif
    arb_in_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (i_valid[k]),
      .pop_i   (pop[k]),
      .wdata_i (wd),
      .full_o  (full[k]),
      .empty_o (empty[k]),
      .rdata_o (head[k])
    );
  end
  assign o_ready = ~full;
  assign req = ~empty;
`ifdef ARB_LOCK_EN
  logic lock_q, lock_d, o_last_q, o_last_d;
  ch_idx_t lch_q, lch_d;
  assign elig = lock_q ? req & (N_CH'(1) << lch_q) : req;
  assign last_g = head_g[FW-1];
  assign o_last = o_last_q;
  always_comb begin
    lock_d = take ? ~last_g : lock_q;
    lch_d = take ? ch_idx_t'(gnt) : lch_q;
    o_last_d = take ? last_g : o_last_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q <= 1'b0;
      lch_q <= '0;
      o_last_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
      lch_q <= lch_d;
      o_last_q <= o_last_d;
    end
  end
`else
  assign elig = req;
  assign last_g = 1'b1;
`endif
  // Scan downward so the surviving match is the nearest one after ptr.
  always_comb begin
    gnt = 0;
    for (int i = N_CH; i >= 1; i--)
      if (elig[(int'(ptr_q) + i) % N_CH]) gnt = (int'(ptr_q) + i) % N_CH;
    load = ~o_valid_q | i_ready;
    take = load & |elig;
    pop = take ? N_CH'(1) << gnt : '0;
    head_g = head[gnt];
  end
  always_comb begin
    o_valid_d = take | (o_valid_q & ~i_ready);
    o_data_d = take ? head_g[DATA_WIDTH-1:0] : o_data_q;
    o_src_d = take ? SW'(gnt) : o_src_q;
    ptr_d = (take & last_g) ? ch_idx_t'(gnt) : ptr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid_q <= 1'b0;
      o_data_q <= '0;
      o_src_q <= '0;
      ptr_q <= ch_idx_t'(ptr_rst(N_CH));
    end else begin
      o_valid_q <= o_valid_d;
      o_data_q <= o_data_d;
      o_src_q <= o_src_d;
      ptr_q <= ptr_d;
    end
  end
  assign o_valid = o_valid_q;
  assign o_data = o_data_q;
  assign o_src = o_src_q;
endmodule

// File: doc/arb_merge_rr_sync.md
Name: arb_merge_rr_sync

Overview:
- Synchronous, parametrised N-to-1 arbitrating merge for the cache control path.
- Successor to the 8-input self-timed merge; this version runs on one clock.
- Each input channel has its own FIFO. A true round-robin arbiter feeds a registered output stage with valid/ready flow control.
- Sits between per-bank request sources and the shared cache request port.

Parameters:
- N_CH, 8, number of input channels (2..16).
- DATA_WIDTH, 8, payload width in bits.
- FIFO_DEPTH, 2, entries per input FIFO (power of two, >=2).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_valid  input  N_CH  per-channel request valid.
- i_data  input  N_CH*DATA_WIDTH  per-channel payload; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_ready  output  N_CH  per-channel accept; equals "FIFO k not full".
- o_valid  output  1  output beat valid.
- o_data  output  DATA_WIDTH  output payload.
- o_src  output  clog2(N_CH)  index of the channel that sourced the current beat.
- i_ready  input  1  downstream accept.

Behaviour:
- Reset (asynchronous, active-high):
  - All FIFOs empty; o_ready = all ones.
  - o_valid = 0, o_data = 0, o_src = 0.
  - Round-robin pointer = N_CH-1, so channel 0 wins first.
  - While rst is high, no push and no pop occur.
  - Asserting rst mid-transfer discards all buffered and output data immediately.
- Push:
  - Channel k pushes on an edge where i_valid[k] & o_ready[k].
  - o_ready[k] depends only on full[k]; it never looks at a same-cycle pop.
  - A full FIFO therefore refuses the push even while it is being popped.
- Request: req[k] = FIFO k non-empty. Entries are visible the cycle after the push edge.
- Load condition: load = ~o_valid | i_ready.
  - When load & |req: grant the first set req searching from ptr+1 upward, wrapping modulo N_CH.
  - Pop that FIFO; o_data <= its head; o_src <= k; o_valid <= 1; ptr <= k.
  - When load & ~|req & i_ready: o_valid <= 0; o_data and o_src hold their last values.
- Hold: while o_valid & ~i_ready, o_data and o_src are stable, nothing pops, and ptr is frozen.
- Latency: a beat accepted on edge e appears on o_valid/o_data after edge e+1 at the earliest. There is no bypass path.
- Throughput: one beat per cycle sustained.
- Fairness: with all channels continuously requesting, grants are 0,1,...,N_CH-1,0,... Any requester waits at most N_CH-1 grants.
- Ordering: per-channel order is preserved.
- FIFO pointers: clog2(FIFO_DEPTH)+1 bits, with the wrap bit used to tell full from empty.

Optional Feature:
- ARB_LOCK_EN.
- Defined:
  - Adds port i_last (input, N_CH) and output o_last (1 bit).
  - i_last is stored in the FIFO alongside the data.
  - Once a beat with last=0 is granted from channel k, only channel k may be granted until a beat with last=1 from k is granted.
  - ptr updates only on the last=1 grant.
  - While locked and FIFO k is empty, no other channel is granted. o_valid drops once the current beat drains.
- Undefined: ports absent; every beat is arbitrated independently.

Decomposition:
- Package arb_merge_pkg holds:
  - a clog2 helper;
  - the type for channel index width;
  - the reset constant for ptr (N_CH-1).
- One sub-module, arb_in_fifo: a parametrised synchronous FIFO with push, pop, full, empty, head data and asynchronous active-high reset.
  - Instantiated N_CH times via generate.
- The arbiter and output register stay in the top level.

Test Plan:
- Reset release, idle: o_valid=0, o_data=0, o_src=0, o_ready=8'hFF. Single push on ch3, data 8'hA5 → o_valid=1, o_src=3, o_data=8'hA5 after the second edge.
- All 8 channels hold 2 beats each (data = 8'h10+k, then 8'h20+k); i_ready=1 → o_src sequence 0..7,0..7, one beat per cycle, 16 beats total.
- Backpressure: i_ready=0 for 5 cycles while o_valid=1 → o_data and o_src unchanged. Channel 2 fills (o_ready[2]=0) after 2 further pushes. On i_ready=1, draining resumes in order.
- Fairness with the pointer mid-range: last grant ch5; ch1 and ch6 pending → ch6 granted, then ch1.
- Assert rst with o_valid=1 and FIFOs non-empty → o_valid=0 and o_ready=all ones immediately (asynchronous). No stale beat after release.
- ARB_LOCK_EN: ch4 sends beats last=0,0,1 while ch0 requests → ch4 beats are output consecutively, then ch0 is granted.
